// File: rtl/itch_rx_arbiter.sv
// Packet-granular round-robin merge of ITCH feeds A/B with max-length truncation and stats.
// Latency: 1 cycle from accepted beat to pkt_* output; 1 beat/cycle throughput, 0-cycle packet gap.
// Backpressure: rdy is combinational, with no path from pkt_*; the output has no rdy and is never stalled.
module itch_rx_arbiter #(
    parameter int MAX_BEATS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      rx_data_a,
    input  logic             rx_sof_a,
    input  logic             rx_eof_a,
    input  logic [2:0]       rx_len_a,
    input  logic             rx_vld_a,
    output logic             rx_rdy_a,
    input  logic [63:0]      rx_data_b,
    input  logic             rx_sof_b,
    input  logic             rx_eof_b,
    input  logic [2:0]       rx_len_b,
    input  logic             rx_vld_b,
    output logic             rx_rdy_b,
    output logic [63:0]      pkt_data,
    output logic             pkt_sof,
    output logic             pkt_eof,
    output logic             pkt_vld,
    output logic [2:0]       pkt_len,
    output logic             active_port,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt_a,
    output logic [CNT_W-1:0] pkt_cnt_b,
    output logic [7:0]       trunc_cnt,
    output logic [7:0]       stray_cnt
);
    typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

    localparam logic [6:0] MAX_B = 7'(MAX_BEATS);

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [6:0]  beat_cnt;

    logic        cand_a, cand_b, any_cand, win, sel_b, acc;
    logic [63:0] beat_data;
    logic        beat_eof;
    logic [2:0]  beat_len;
    logic [6:0]  beat_next;

    always_comb begin
        cand_a   = rx_vld_a & rx_sof_a;
        cand_b   = rx_vld_b & rx_sof_b;
        any_cand = cand_a | cand_b;
        // On a tie the port that did not win last time goes next.
        win      = (cand_a & cand_b) ? ~last_grant : cand_b;
        rx_rdy_a = 1'b0;
        rx_rdy_b = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                if (any_cand) begin
                    rx_rdy_a = ~win;
                    rx_rdy_b = win;
                end else begin
                    rx_rdy_a = rx_vld_a;
                    rx_rdy_b = rx_vld_b;
                end
            end else begin
                rx_rdy_a = ~grant;
                rx_rdy_b = grant;
            end
        end
        sel_b     = (state == IDLE) ? win : grant;
        beat_data = sel_b ? rx_data_b : rx_data_a;
        beat_eof  = sel_b ? rx_eof_b : rx_eof_a;
        beat_len  = sel_b ? rx_len_b : rx_len_a;
        acc       = sel_b ? (rx_vld_b & rx_rdy_b) : (rx_vld_a & rx_rdy_a);
        beat_next = beat_cnt + 7'd1;
    end

    assign active_port = grant;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            pkt_data   <= '0;
            pkt_sof    <= 1'b0;
            pkt_eof    <= 1'b0;
            pkt_vld    <= 1'b0;
            pkt_len    <= '0;
            pkt_cnt_a  <= '0;
            pkt_cnt_b  <= '0;
            trunc_cnt  <= '0;
            stray_cnt  <= '0;
        end else begin
            pkt_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_cand) begin
                        grant      <= win;
                        last_grant <= win;
                        pkt_vld    <= 1'b1;
                        pkt_data   <= beat_data;
                        pkt_sof    <= 1'b1;
                        pkt_eof    <= beat_eof;
                        pkt_len    <= beat_len;
                        if (beat_eof) begin
                            if (sel_b) pkt_cnt_b <= pkt_cnt_b + CNT_W'(1);
                            else       pkt_cnt_a <= pkt_cnt_a + CNT_W'(1);
                        end else begin
                            state    <= GRANT;
                            beat_cnt <= 7'd1;
                        end
                    end else if ((rx_vld_a | rx_vld_b) && stray_cnt != 8'hff) begin
                        stray_cnt <= stray_cnt + 8'd1;
                    end
                end
                GRANT: begin
                    if (acc) begin
                        pkt_vld  <= 1'b1;
                        pkt_data <= beat_data;
                        pkt_sof  <= 1'b0;
                        beat_cnt <= beat_next;
                        if (beat_eof) begin
                            pkt_eof <= 1'b1;
                            pkt_len <= beat_len;
                            state   <= IDLE;
                            if (sel_b) pkt_cnt_b <= pkt_cnt_b + CNT_W'(1);
                            else       pkt_cnt_a <= pkt_cnt_a + CNT_W'(1);
                        end else if (beat_next == MAX_B) begin
                            pkt_eof <= 1'b1;
                            pkt_len <= 3'd7;
                            state   <= FLUSH;
                            if (trunc_cnt != 8'hff) trunc_cnt <= trunc_cnt + 8'd1;
                        end else begin
                            pkt_eof <= 1'b0;
                            pkt_len <= beat_len;
                        end
                    end
                end
                FLUSH: begin
                    if (acc && beat_eof) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_itch_rx_arbiter.sv
// Directed table of per-cycle inputs and expected outputs, plus a mid-packet reset sequence.
module tb_itch_rx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rx_data_a, rx_data_b;
    logic        rx_sof_a, rx_eof_a, rx_vld_a, rx_rdy_a;
    logic        rx_sof_b, rx_eof_b, rx_vld_b, rx_rdy_b;
    logic [2:0]  rx_len_a, rx_len_b;
    logic [63:0] pkt_data;
    logic        pkt_sof, pkt_eof, pkt_vld;
    logic [2:0]  pkt_len;
    logic        active_port, busy;
    logic [15:0] pkt_cnt_a, pkt_cnt_b;
    logic [7:0]  trunc_cnt, stray_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [55:0] DA = 56'hA0A0_A0A0_A0A0_A0;
    localparam logic [55:0] DB = 56'hB0B0_B0B0_B0B0_B0;

    itch_rx_arbiter #(.MAX_BEATS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data_a(rx_data_a), .rx_sof_a(rx_sof_a), .rx_eof_a(rx_eof_a),
        .rx_len_a(rx_len_a), .rx_vld_a(rx_vld_a), .rx_rdy_a(rx_rdy_a),
        .rx_data_b(rx_data_b), .rx_sof_b(rx_sof_b), .rx_eof_b(rx_eof_b),
        .rx_len_b(rx_len_b), .rx_vld_b(rx_vld_b), .rx_rdy_b(rx_rdy_b),
        .pkt_data(pkt_data), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof),
        .pkt_vld(pkt_vld), .pkt_len(pkt_len),
        .active_port(active_port), .busy(busy),
        .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b),
        .trunc_cnt(trunc_cnt), .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       va, sa, ea; logic [2:0] la;
        logic       vb, sb, eb; logic [2:0] lb;
        logic       ra, rb, pv, ps, pe; logic [2:0] pl;
        logic       ap, bz;
        int         ca, cb, tc, sc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic va, sa, ea, input logic [2:0] la,
        input logic vb, sb, eb, input logic [2:0] lb,
        input logic ra, rb, pv, ps, pe, input logic [2:0] pl,
        input logic ap, bz, input int ca, cb, tc, sc);
        vec_t r;
        r.va = va; r.sa = sa; r.ea = ea; r.la = la;
        r.vb = vb; r.sb = sb; r.eb = eb; r.lb = lb;
        r.ra = ra; r.rb = rb; r.pv = pv; r.ps = ps; r.pe = pe; r.pl = pl;
        r.ap = ap; r.bz = bz; r.ca = ca; r.cb = cb; r.tc = tc; r.sc = sc;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic va, sa, ea, input logic [2:0] la,
                         input logic vb, sb, eb, input logic [2:0] lb, input int tag);
        rx_vld_a = va; rx_sof_a = sa; rx_eof_a = ea; rx_len_a = la;
        rx_vld_b = vb; rx_sof_b = sb; rx_eof_b = eb; rx_len_b = lb;
        rx_data_a = {DA, 8'(tag)};
        rx_data_b = {DB, 8'(tag)};
    endtask

    initial begin
        //          A: v s e len   B: v s e len | ra rb pv ps pe pl ap bz  ca cb tc sc
        vecs.push_back(v(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,0,0)); // 0 reset state
        vecs.push_back(v(1,1,0,0, 1,1,0,0, 1,0, 0,0,0,0, 0,0, 0,0,0,0)); // 1 tie -> A
        vecs.push_back(v(1,0,1,5, 1,1,0,0, 1,0, 1,1,0,0, 0,1, 0,0,0,0));
        vecs.push_back(v(1,1,0,0, 1,1,0,0, 0,1, 1,0,1,5, 0,0, 1,0,0,0)); // 3 tie -> B
        vecs.push_back(v(1,1,0,0, 1,0,1,3, 0,1, 1,1,0,0, 1,1, 1,0,0,0));
        vecs.push_back(v(1,1,0,0, 1,1,0,0, 1,0, 1,0,1,3, 1,0, 1,1,0,0)); // 5 tie -> A
        vecs.push_back(v(1,0,1,6, 1,1,0,0, 1,0, 1,1,0,0, 0,1, 1,1,0,0));
        vecs.push_back(v(0,0,0,0, 1,1,0,0, 0,1, 1,0,1,6, 0,0, 2,1,0,0));
        vecs.push_back(v(0,0,0,0, 1,0,1,0, 0,1, 1,1,0,0, 1,1, 2,1,0,0));
        vecs.push_back(v(0,0,0,0, 0,0,0,0, 0,0, 1,0,1,0, 1,0, 2,2,0,0));
        vecs.push_back(v(1,1,0,0, 0,0,0,0, 1,0, 0,0,0,0, 1,0, 2,2,0,0)); // 10 oversize A
        vecs.push_back(v(1,0,0,0, 0,0,0,0, 1,0, 1,1,0,0, 0,1, 2,2,0,0));
        vecs.push_back(v(1,0,0,0, 0,0,0,0, 1,0, 1,0,0,0, 0,1, 2,2,0,0));
        vecs.push_back(v(1,0,0,0, 0,0,0,0, 1,0, 1,0,0,0, 0,1, 2,2,0,0));
        vecs.push_back(v(1,0,0,0, 0,0,0,0, 1,0, 1,0,1,7, 0,1, 2,2,1,0)); // 14 forced eof
        vecs.push_back(v(1,0,1,4, 1,1,0,0, 1,0, 0,0,0,0, 0,1, 2,2,1,0));
        vecs.push_back(v(0,0,0,0, 1,1,0,0, 0,1, 0,0,0,0, 0,0, 2,2,1,0));
        vecs.push_back(v(0,0,0,0, 1,0,1,1, 0,1, 1,1,0,0, 1,1, 2,2,1,0));
        vecs.push_back(v(0,0,0,0, 0,0,0,0, 0,0, 1,0,1,1, 1,0, 2,3,1,0));
        vecs.push_back(v(0,0,0,0, 1,0,0,0, 0,1, 0,0,0,0, 1,0, 2,3,1,0)); // 19 stray B
        vecs.push_back(v(0,0,0,0, 1,0,0,0, 0,1, 0,0,0,0, 1,0, 2,3,1,1));
        vecs.push_back(v(1,0,0,0, 1,0,0,0, 1,1, 0,0,0,0, 1,0, 2,3,1,2)); // 21 both stray
        vecs.push_back(v(1,1,1,0, 1,0,0,0, 1,0, 0,0,0,0, 1,0, 2,3,1,3)); // 22 single beat
        vecs.push_back(v(1,1,0,0, 0,0,0,0, 1,0, 1,1,1,0, 0,0, 3,3,1,3));
        vecs.push_back(v(1,1,1,3, 0,0,0,0, 1,0, 1,1,0,0, 0,1, 3,3,1,3)); // 24 sof ignored
        vecs.push_back(v(0,0,0,0, 0,0,0,0, 0,0, 1,0,1,3, 0,0, 4,3,1,3));

        rst = 1'b0;
        drive(0,0,0,0, 0,0,0,0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].va, vecs[i].sa, vecs[i].ea, vecs[i].la,
                  vecs[i].vb, vecs[i].sb, vecs[i].eb, vecs[i].lb, i);
            #1;
            chk("rdy_a", i, 64'(rx_rdy_a), 64'(vecs[i].ra));
            chk("rdy_b", i, 64'(rx_rdy_b), 64'(vecs[i].rb));
            chk("pkt_vld", i, 64'(pkt_vld), 64'(vecs[i].pv));
            chk("active_port", i, 64'(active_port), 64'(vecs[i].ap));
            chk("busy", i, 64'(busy), 64'(vecs[i].bz));
            chk("pkt_cnt_a", i, 64'(pkt_cnt_a), 64'(vecs[i].ca));
            chk("pkt_cnt_b", i, 64'(pkt_cnt_b), 64'(vecs[i].cb));
            chk("trunc_cnt", i, 64'(trunc_cnt), 64'(vecs[i].tc));
            chk("stray_cnt", i, 64'(stray_cnt), 64'(vecs[i].sc));
            if (vecs[i].pv) begin
                chk("pkt_sof", i, 64'(pkt_sof), 64'(vecs[i].ps));
                chk("pkt_eof", i, 64'(pkt_eof), 64'(vecs[i].pe));
                chk("pkt_len", i, 64'(pkt_len), 64'(vecs[i].pl));
                chk("pkt_data", i, pkt_data, {(vecs[i].ap ? DB : DA), 8'(i - 1)});
            end
            @(negedge clk);
        end

        // Reset asserted during beat 2 of a 4-beat A packet.
        drive(1,1,0,0, 0,0,0,0, 8'h40);
        @(negedge clk);
        drive(1,0,0,0, 0,0,0,0, 8'h41);
        #2 rst = 1'b0;
        #1;
        chk("rst_pkt_vld", 100, 64'(pkt_vld), 64'd0);
        chk("rst_pkt_sof", 100, 64'(pkt_sof), 64'd0);
        chk("rst_pkt_data", 100, pkt_data, 64'd0);
        chk("rst_busy", 100, 64'(busy), 64'd0);
        chk("rst_active_port", 100, 64'(active_port), 64'd0);
        chk("rst_pkt_cnt_a", 100, 64'(pkt_cnt_a), 64'd0);
        chk("rst_stray_cnt", 100, 64'(stray_cnt), 64'd0);
        chk("rst_trunc_cnt", 100, 64'(trunc_cnt), 64'd0);
        chk("rst_rdy_a", 100, 64'(rx_rdy_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1,0,0,0, 0,0,0,0, 8'h42);
        #1;
        chk("post_rdy_a", 101, 64'(rx_rdy_a), 64'd1);
        @(negedge clk);
        drive(1,0,1,2, 0,0,0,0, 8'h43);
        #1;
        chk("post_stray1", 102, 64'(stray_cnt), 64'd1);
        chk("post_busy", 102, 64'(busy), 64'd0);
        @(negedge clk);
        drive(0,0,0,0, 1,1,1,5, 8'h44);
        #1;
        chk("post_stray2", 103, 64'(stray_cnt), 64'd2);
        chk("post_rdy_b", 103, 64'(rx_rdy_b), 64'd1);
        chk("post_pkt_vld_idle", 103, 64'(pkt_vld), 64'd0);
        @(negedge clk);
        drive(0,0,0,0, 0,0,0,0, 8'h45);
        #1;
        chk("b_pkt_vld", 104, 64'(pkt_vld), 64'd1);
        chk("b_pkt_sof", 104, 64'(pkt_sof), 64'd1);
        chk("b_pkt_eof", 104, 64'(pkt_eof), 64'd1);
        chk("b_pkt_len", 104, 64'(pkt_len), 64'd5);
        chk("b_pkt_data", 104, pkt_data, {DB, 8'h44});
        chk("b_active_port", 104, 64'(active_port), 64'd1);
        chk("b_pkt_cnt_b", 104, 64'(pkt_cnt_b), 64'd1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
